mips_timer_mmio: RTL



---
 rtl/mips_mmio_pkg.sv | 26 ++
 rtl/mips_prescaler.sv | 47 ++++
 rtl/mips_timer_mmio.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the MIPS memory-mapped peripherals.
// Holds the timer register index map, the CTRL bit positions and the
// default window base address.
package mips_mmio_pkg;

    // Register indices, taken from memaddr[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_PRESC  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Default window base; the low five bits must stay zero
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    // Word register index of a byte address inside the 32-byte window
    function automatic logic [2:0] reg_index(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/mips_prescaler.sv
// Prescaler for the MMIO timer.
// Ports:
//   clk, reset  - clock and asynchronous active-low reset
//   en          - count enable; pcnt is held at zero while low
//   clr         - synchronous clear of pcnt (store to CTRL or COUNT)
//   presc       - terminal value; tick period is presc+1 cycles
//   tick        - high during the cycle whose closing edge is a tick
module mips_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt_q;
    logic [PRESC_W-1:0] pcnt_d;

    // The tick is not masked by clr: a CTRL store on an expiry edge still
    // lets the expiry happen; a COUNT store overrides it in the top.
    assign tick = en && (pcnt_q == presc);

    // Next prescaler count
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr || !en) begin
            pcnt_d = {PRESC_W{1'b0}};
        end else if (pcnt_q == presc) begin
            pcnt_d = {PRESC_W{1'b0}};
        end else begin
            pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= {PRESC_W{1'b0}};
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mips_timer_mmio.sv
// Memory-mapped countdown timer on the single-cycle MIPS data bus.
// Ports:
//   clk, reset     - clock and asynchronous active-low reset
//   memwrite       - store strobe
//   memaddr        - byte address; window decoded on [31:5], index [4:2]
//   memwritedata   - store data
//   memreaddata    - combinational load data, 0 when not selected
//   sel            - address falls inside this block's window
//   irq            - expired & irq_en
module mips_timer_mmio
    import mips_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        sel,
    output logic        irq
);

    logic [2:0]         ctrl_q,    ctrl_d;
    logic [31:0]        load_q,    load_d;
    logic [31:0]        count_q,   count_d;
    logic               expired_q, expired_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;

    logic [2:0]         idx_s;
    logic               wr_s;
    logic               pclr_s;
    logic               tick_s;
    logic [31:0]        rdata_s;
    logic               unused_s;

    assign sel      = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign idx_s    = reg_index(memaddr);
    assign wr_s     = sel && memwrite;
    assign pclr_s   = wr_s && ((idx_s == REG_CTRL) || (idx_s == REG_COUNT));
    assign irq      = expired_q && ctrl_q[CTRL_IRQ_EN];
    assign unused_s = &{1'b0, memaddr[1:0]};

    mips_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_q[CTRL_EN]),
        .clr   (pclr_s),
        .presc (presc_q),
        .tick  (tick_s)
    );

    // Register bank next state. Order matters: the STATUS clear is applied
    // before the tick so a simultaneous expiry wins, and stores to CTRL/COUNT
    // are applied after the tick so the stored value wins.
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        presc_d   = presc_q;

        if (wr_s && (idx_s == REG_STATUS) && memwritedata[0]) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end

        if (tick_s) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[CTRL_RELOAD]) begin
                    count_d = load_q;
                end else begin
                    count_d         = 32'd0;
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end else begin
            count_d = count_q;
        end

        if (wr_s) begin
            case (idx_s)
                REG_CTRL:  ctrl_d  = memwritedata[2:0];
                REG_LOAD:  load_d  = memwritedata;
                REG_COUNT: count_d = memwritedata;
                REG_PRESC: presc_d = memwritedata[PRESC_W-1:0];
                default:   ; // STATUS handled above, 5-7 ignore writes
            endcase
        end else begin
            presc_d = presc_q;
        end
    end

    // Register bank state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= 3'd0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            expired_q <= 1'b0;
            presc_q   <= {PRESC_W{1'b0}};
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            presc_q   <= presc_d;
        end
    end

    // Combinational read mux
    always_comb begin
        case (idx_s)
            REG_CTRL:   rdata_s = {29'd0, ctrl_q};
            REG_LOAD:   rdata_s = load_q;
            REG_COUNT:  rdata_s = count_q;
            REG_STATUS: rdata_s = {31'd0, expired_q};
            REG_PRESC:  rdata_s = {{(32-PRESC_W){1'b0}}, presc_q};
            default:    rdata_s = 32'd0;
        endcase
        if (sel) begin
            memreaddata = rdata_s;
        end else begin
            memreaddata = 32'd0;
        end
    end

endmodule
